// File: rtl/e203_exu_wbck_arb_pkg.sv
// e203_exu_wbck_arb_pkg: shared widths, defaults and writeback payload type
package e203_exu_wbck_arb_pkg;
  localparam int XLEN = 32;
  localparam int RFIDX_W = 5;
  localparam int LP_DEPTH_DEF = 2;
  localparam int STARVE_MAX_DEF = 3;
  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    wdat;
  } wbck_t;
endpackage

// File: rtl/e203_exu_wbck_lpfifo.sv
// e203_exu_wbck_lpfifo: circular buffer holding long-pipe writeback results
module e203_exu_wbck_lpfifo
  import e203_exu_wbck_arb_pkg::*;
#(
  parameter int  DEPTH = LP_DEPTH_DEF,
  parameter type T = wbck_t,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);
  T mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rptr];
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/e203_exu_wbck_arb.sv
// e203_exu_wbck_arb: merges ALU and buffered long-pipe results onto the regfile write port
module e203_exu_wbck_arb
  import e203_exu_wbck_arb_pkg::*;
#(
  parameter int  XLEN_P = XLEN,
  parameter int  RFIDX_P = RFIDX_W,
  parameter int  LP_DEPTH = LP_DEPTH_DEF,
  parameter int  STARVE_MAX = STARVE_MAX_DEF,
  localparam int CW = $clog2(LP_DEPTH + 1),
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN_P-1:0]  alu_wbck_i_wdat,
  input  logic [RFIDX_P-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN_P-1:0]  longp_wbck_i_wdat,
  input  logic [RFIDX_P-1:0] longp_wbck_i_rdidx,
  output logic               rf_wbck_o_ena,
  output logic [XLEN_P-1:0]  rf_wbck_o_wdat,
  output logic [RFIDX_P-1:0] rf_wbck_o_rdidx,
  output logic               longp_pend,
  output logic [CW-1:0]      lp_cnt
);
  typedef struct packed {
    logic [RFIDX_P-1:0] rdidx;
    logic [XLEN_P-1:0]  wdat;
  } pl_t;
  pl_t din, head;
  logic full, empty, force_alu, lp_pop, alu_hs;
  logic [SW-1:0] starve_cnt;
  assign din = '{rdidx: longp_wbck_i_rdidx, wdat: longp_wbck_i_wdat};
  e203_exu_wbck_lpfifo #(.DEPTH(LP_DEPTH), .T(pl_t)) u_lpfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (longp_wbck_i_valid & ~full),
    .pop   (lp_pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .cnt   (lp_cnt)
  );
  // a starved ALU steals the port for one cycle; the FIFO head just waits
  assign force_alu          = alu_wbck_i_valid & (starve_cnt == SW'(STARVE_MAX));
  assign lp_pop             = ~empty & ~force_alu;
  assign alu_wbck_i_ready   = empty | force_alu;
  assign alu_hs             = alu_wbck_i_valid & alu_wbck_i_ready;
  assign longp_wbck_i_ready = ~full;
  assign longp_pend         = ~empty;
  assign rf_wbck_o_wdat     = alu_wbck_i_ready ? alu_wbck_i_wdat : head.wdat;
  assign rf_wbck_o_rdidx    = alu_wbck_i_ready ? alu_wbck_i_rdidx : head.rdidx;
  assign rf_wbck_o_ena      = (lp_pop | alu_hs) & (rf_wbck_o_rdidx != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else if (!alu_wbck_i_valid | alu_hs) starve_cnt <= '0;
    else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  end
endmodule
